// File: rtl/multicycle_control.sv
// Main sequencing FSM for the non-pipelined MIPS CPU: steps each instruction through
// fetch/decode/execute/memory/writeback and drives all datapath controls from the state.
module multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOp_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    opcode,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [ALUOp_WIDTH-1:0] ALUOp,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [3:0]             state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);

  localparam logic [ALUOp_WIDTH-1:0] ALU_ADD  = ALUOp_WIDTH'(0);
  localparam logic [ALUOp_WIDTH-1:0] ALU_SUB  = ALUOp_WIDTH'(1);
  localparam logic [ALUOp_WIDTH-1:0] ALU_FUNC = ALUOp_WIDTH'(2);

  state_t curState, nextState;

  always_ff @(posedge clk) begin
    if (rst) curState <= FETCH;
    else     curState <= nextState;
  end

  // Reset blanks every control so nothing in the datapath moves while held.
  assign state = rst ? 4'd0 : curState;

  always_comb begin
    nextState   = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (curState)
        FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = 2'b01;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          nextState = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (opcode == OP_LW || opcode == OP_SW) nextState = MEMADR;
          else if (opcode == OP_RTYPE)            nextState = EXEC;
          else if (opcode == OP_BEQ)              nextState = BRANCH;
          else if (opcode == OP_J)                nextState = JUMP;
          else if (opcode == OP_ADDI)             nextState = ADDI_EX;
          else begin
            illegal_op = 1'b1;
            nextState  = FETCH;
          end
        end
        MEMADR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          MemRead   = 1'b1;
          IorD      = 1'b1;
          nextState = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          nextState  = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA   = 1'b1;
          ALUOp     = ALU_FUNC;
          nextState = RWB;
        end
        RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        ADDI_EX: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          nextState = ADDI_WB;
        end
        ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: nextState = FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the non-pipelined MIPS CPU. Walks each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also supplies the 2-bit ALUOp consumed by ALUcontrol: 00 = add, 01 = subtract, 10 = decode by func. Memory accesses use a ready handshake, so the controller stalls cleanly on slow memory.

## Interface
- `OP_WIDTH`, default 6: opcode field width (instr[31:26]).
- `ALUOp_WIDTH`, default 2: ALUOp width; must match ALUcontrol.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `opcode`  in  OP_WIDTH: instruction register opcode field; valid from DECODE onward.
- `mem_ready`  in  1: memory has completed the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each: standard multicycle datapath controls.
- `ALUSrcB`  out  2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `PCSource`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp`  out  ALUOp_WIDTH: to ALUcontrol.
- `instr_done`  out  1: one-cycle pulse in the final cycle of each legal instruction.
- `illegal_op`  out  1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state`  out  4: current state encoding, for debug and verification.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- State encodings and outputs. Any output not listed is 0.
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only in the cycle mem_ready=1. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - lw or sw → MEMADR
    - R-type → EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDI_EX
    - anything else → FETCH, with illegal_op=1 for this cycle.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw.
  - MEMRD (3): MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
  - MEMWR (5): MemWrite=1, IorD=1. Holds until mem_ready=1; instr_done=1 in that cycle, then goes to FETCH.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
  - RWB (7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
  - JUMP (9): PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
  - ADDI_EX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDI_WB.
  - ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next state FETCH.
- Unused encodings 12–15 go to FETCH on the next edge. All outputs are 0 in these states.
- Outputs are decoded combinationally from `state`. A small set of outputs also depends on input signals:
  - IRWrite and PCWrite in FETCH are qualified by mem_ready.
  - instr_done in MEMWR is qualified by mem_ready.
  - illegal_op in DECODE is qualified by opcode.
- MemRead and MemWrite stay asserted for every cycle of a stall.
- opcode is sampled only in DECODE and MEMADR. Its value in other states is don't-care.

## Timing
- Reset: rst=1 at a rising edge sets state=FETCH (0). rst has priority over every transition, including mid-stall and mid-instruction.
- While rst=1, every output is forced to 0 and state reads 0.
- First fetch: MemRead=1 in the first cycle after rst falls.
- Cycles per instruction with mem_ready held at 1:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Illegal opcode costs 2 cycles (FETCH, DECODE) and produces no register, memory or PC writes beyond the fetch's PC+4.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset behaviour: hold rst=1 for 3 cycles. Expect state=0 and all outputs 0. Release rst with mem_ready=1. Expect MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01 in the next cycle.
- R-type (opcode 000000), mem_ready=1: expect state sequence 0,1,6,7,0. ALUOp=10 only in state 6. RegWrite=1 with RegDst=1 only in state 7. instr_done pulses once.
- lw (opcode 100011) with mem_ready=0 for 2 cycles in MEMRD: expect sequence 0,1,2,3,3,3,4,0. MemRead and IorD stay high for all three MEMRD cycles. RegWrite=1 with MemtoReg=1 in state 4. Total 7 cycles.
- beq (opcode 000100), then j (opcode 000010):
  - beq: ALUOp=01, PCWriteCond=1, PCSource=01 in state 8.
  - j: PCWrite=1, PCSource=10 in state 9.
  - Each instruction completes in 3 cycles.
- Illegal opcode 111111: illegal_op=1 for exactly one cycle in DECODE. Next state 0. No RegWrite, MemWrite or PCWriteCond at any point.
- Reset mid-operation: assert rst in MEMWR while mem_ready=0. Expect state=0 and MemWrite=0 at the next edge. The following fetch proceeds normally.
